// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: pipeline hazard controller for the 5-stage RV32 core.
// Resolves M/W forwarding, load-use stalls and taken-branch flushes.
// Also tracks a sequential multi-cycle execute op (MUL/DIV): it holds
// F/D/E for MD_LAT-1 cycles and bubbles M while the op sits in E.
// Optional macro HAZ_PERF_CNT_EN adds StallCycles/FlushCount counters.
module hazard_ctrl_mc #(
  parameter int          REG_AW   = 5,
  parameter int          MD_LAT   = 4,
  parameter logic [1:0]  LOAD_SRC = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              MdStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MdBusy,
`ifdef HAZ_PERF_CNT_EN
  output logic              MdDone,
  output logic [31:0]       StallCycles,
  output logic [31:0]       FlushCount
`else
  output logic              MdDone
`endif
);

  // Counter is at least one bit wide so MD_LAT of 1 or 2 still elaborates.
  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  // BUSY lasts MD_LAT-2 cycles; the counter runs down to zero inside BUSY.
  localparam logic [CW-1:0] CNT_LOAD = (MD_LAT > 2) ? CW'(MD_LAT - 3) : '0;
  localparam bit MULTI_LAT = (MD_LAT > 1);
  localparam bit SHORT_LAT = (MD_LAT == 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_t;

  mdState_t      stateReg, stateNext;
  logic [CW-1:0] cntReg, cntNext;
  logic          mdStall;
  logic          mdDoneRaw;
  logic          loadUse;

  // Forwarding: operand 0 is Rs1E, operand 1 is Rs2E; M beats W.
  logic [REG_AW-1:0] rsE [2];
  logic [1:0]        fwdSel [2];

  assign rsE[0] = Rs1E;
  assign rsE[1] = Rs2E;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwdSel[gi] =
        (RegWriteM && (RdM != '0) && (RdM == rsE[gi])) ? 2'b10 :
        (RegWriteW && (RdW != '0) && (RdW == rsE[gi])) ? 2'b01 :
                                                          2'b00;
    end
  endgenerate

  assign loadUse = (ResultSrcE == LOAD_SRC) && (RdE != '0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  // Multi-cycle tracker state register with synchronous abort on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  // Next-state logic plus the raw stall/done indications of the tracker.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    mdStall   = 1'b0;
    mdDoneRaw = 1'b0;
    case (stateReg)
      IDLE: begin
        if (MdStartE) begin
          if (MULTI_LAT) begin
            mdStall = 1'b1;
            if (SHORT_LAT) begin
              stateNext = DONE;
            end else begin
              stateNext = BUSY;
              cntNext   = CNT_LOAD;
            end
          end else begin
            // Single-cycle latency: the op completes in its first E cycle.
            mdDoneRaw = 1'b1;
          end
        end
      end
      BUSY: begin
        mdStall = 1'b1;
        if (cntReg == '0) begin
          stateNext = DONE;
        end else begin
          cntNext = cntReg - CW'(1);
        end
      end
      DONE: begin
        // MdStartE is still high here (same instruction), so it is ignored.
        mdDoneRaw = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Output combine: a held E stage wins over any flush of D/E; everything
  // is forced low while reset is asserted.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    MdBusy    = 1'b0;
    MdDone    = 1'b0;
    if (!rst) begin
      ForwardAE = fwdSel[0];
      ForwardBE = fwdSel[1];
      StallF    = mdStall | loadUse;
      StallD    = mdStall | loadUse;
      StallE    = mdStall;
      FlushM    = mdStall;
      FlushE    = ~mdStall & (loadUse | PCSrcE);
      FlushD    = ~mdStall & PCSrcE;
      MdBusy    = (stateReg != IDLE);
      MdDone    = mdDoneRaw;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stallCyclesReg;
  logic [31:0] flushCountReg;

  // Performance counters: stalled-fetch cycles and cycles with any flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCyclesReg <= '0;
      flushCountReg  <= '0;
    end else begin
      if (StallF) begin
        stallCyclesReg <= stallCyclesReg + 32'd1;
      end
      if (FlushD || FlushE || FlushM) begin
        flushCountReg <= flushCountReg + 32'd1;
      end
    end
  end

  assign StallCycles = stallCyclesReg;
  assign FlushCount  = flushCountReg;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Testbench for hazard_ctrl_mc: directed steps followed by random cycles,
// every cycle compared against a cycle-phase reference model.
// Build with HAZ_PERF_CNT_EN defined to also check the perf counters.
module tb_hazard_ctrl_mc;

  localparam int AW  = 5;
  localparam int MDL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWriteM, RegWriteW, PCSrcE, MdStartE;
  logic [AW-1:0] RdM, RdW, Rs1E, Rs2E, RdE, Rs1D, Rs2D;
  logic [1:0]    ResultSrcE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDone;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   StallCycles, FlushCount;
`endif

  hazard_ctrl_mc #(.REG_AW(AW), .MD_LAT(MDL), .LOAD_SRC(2'b01)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .Rs1D(Rs1D), .Rs2D(Rs2D), .MdStartE(MdStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MdBusy(MdBusy),
`ifdef HAZ_PERF_CNT_EN
    .MdDone(MdDone), .StallCycles(StallCycles), .FlushCount(FlushCount)
`else
    .MdDone(MdDone)
`endif
  );

  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail   = 0;
  int stepNo  = 0;

  // Reference model: mdPhase = number of E cycles the current op has
  // already spent (0 = no op in flight).
  int          mdPhase = 0;
  logic [31:0] refStall = 0, refFlush = 0;
  logic        eStall, eFlushAny;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwdRef(logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic setIdle();
    rst = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MdStartE = 0;
    RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0; RdE = 0; Rs1D = 0; Rs2D = 0;
    ResultSrcE = 2'b00;
  endtask

  // Compare all outputs at the falling edge against the model.
  task automatic evalCycle(string tag);
    logic [1:0] eFa, eFb;
    logic hold, lu, eDone, eBusy, eFD, eFE, eFM, eSE;
    @(negedge clk);
    stepNo++;
    eFa = 0; eFb = 0; eStall = 0; eSE = 0; eFD = 0; eFE = 0; eFM = 0;
    eBusy = 0; eDone = 0;
    if (!rst) begin
      eFa   = fwdRef(Rs1E);
      eFb   = fwdRef(Rs2E);
      lu    = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      hold  = (mdPhase == 0) ? (MdStartE && MDL > 1) : (mdPhase < MDL - 1);
      eDone = (mdPhase == 0) ? (MdStartE && MDL == 1) : (mdPhase == MDL - 1);
      eBusy = (mdPhase != 0);
      eStall = hold || lu;
      eSE   = hold;
      eFM   = hold;
      eFE   = !hold && (lu || PCSrcE);
      eFD   = !hold && PCSrcE;
    end
    eFlushAny = eFD || eFE || eFM;
    $display("step %0d %s: fa=%b fb=%b sF=%b sD=%b sE=%b fD=%b fE=%b fM=%b busy=%b done=%b",
             stepNo, tag, ForwardAE, ForwardBE, StallF, StallD, StallE,
             FlushD, FlushE, FlushM, MdBusy, MdDone);
    chk({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(eFa));
    chk({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(eFb));
    chk({tag, ".StallF"},    32'(StallF),    32'(eStall));
    chk({tag, ".StallD"},    32'(StallD),    32'(eStall));
    chk({tag, ".StallE"},    32'(StallE),    32'(eSE));
    chk({tag, ".FlushD"},    32'(FlushD),    32'(eFD));
    chk({tag, ".FlushE"},    32'(FlushE),    32'(eFE));
    chk({tag, ".FlushM"},    32'(FlushM),    32'(eFM));
    chk({tag, ".MdBusy"},    32'(MdBusy),    32'(eBusy));
    chk({tag, ".MdDone"},    32'(MdDone),    32'(eDone));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, ".StallCycles"}, StallCycles, refStall);
    chk({tag, ".FlushCount"},  FlushCount,  refFlush);
`endif
  endtask

  // Clock edge: advance the model with the inputs that were just sampled.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      mdPhase  = 0;
      refStall = 0;
      refFlush = 0;
    end else begin
      if (mdPhase == 0) begin
        if (MdStartE && MDL > 1) mdPhase = 1;
      end else if (mdPhase == MDL - 1) begin
        mdPhase = 0;
      end else begin
        mdPhase++;
      end
      if (eStall)    refStall = refStall + 1;
      if (eFlushAny) refFlush = refFlush + 1;
    end
    #1;
  endtask

  initial begin
    // Reset with forwarding/branch conditions present: outputs must stay 0.
    setIdle();
    rst = 1; RegWriteM = 1; RdM = 5; Rs1E = 5; PCSrcE = 1; MdStartE = 1;
    evalCycle("reset0");
    chk("reset0.ForwardAE_const", 32'(ForwardAE), 32'd0);
    chk("reset0.FlushD_const", 32'(FlushD), 32'd0);
    advance();
    evalCycle("reset1");
    advance();

    // Forwarding: M beats W, then W when M targets x0.
    setIdle();
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
    evalCycle("fwd_m");
    chk("fwd_m.ForwardAE_const", 32'(ForwardAE), 32'd2);
    chk("fwd_m.ForwardBE_const", 32'(ForwardBE), 32'd0);
    advance();
    RdM = 0;
    evalCycle("fwd_w");
    chk("fwd_w.ForwardAE_const", 32'(ForwardAE), 32'd1);
    advance();

    // Load-use hazard, then the same with RdE = x0.
    setIdle();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    evalCycle("lu");
    chk("lu.StallF_const", 32'(StallF), 32'd1);
    chk("lu.FlushE_const", 32'(FlushE), 32'd1);
    chk("lu.FlushD_const", 32'(FlushD), 32'd0);
    advance();
    setIdle();
    evalCycle("lu_gone");
    advance();
    ResultSrcE = 2'b01; RdE = 0; Rs2D = 0;
    evalCycle("lu_x0");
    chk("lu_x0.StallF_const", 32'(StallF), 32'd0);
    advance();

    // Multi-cycle op from T, with branch + load-use at T+1.
    setIdle();
    MdStartE = 1;
    evalCycle("md_T");
    chk("md_T.StallE_const", 32'(StallE), 32'd1);
    chk("md_T.MdBusy_const", 32'(MdBusy), 32'd0);
    advance();
    PCSrcE = 1; ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    evalCycle("md_T1");
    chk("md_T1.FlushD_const", 32'(FlushD), 32'd0);
    chk("md_T1.FlushE_const", 32'(FlushE), 32'd0);
    chk("md_T1.StallE_const", 32'(StallE), 32'd1);
    advance();
    PCSrcE = 0; ResultSrcE = 2'b00;
    evalCycle("md_T2");
    chk("md_T2.FlushM_const", 32'(FlushM), 32'd1);
    advance();
    evalCycle("md_T3");
    chk("md_T3.MdDone_const", 32'(MdDone), 32'd1);
    chk("md_T3.StallE_const", 32'(StallE), 32'd0);
    advance();
    MdStartE = 0; PCSrcE = 1;
    evalCycle("md_T4");
    chk("md_T4.MdBusy_const", 32'(MdBusy), 32'd0);
    chk("md_T4.FlushD_const", 32'(FlushD), 32'd1);
    chk("md_T4.FlushE_const", 32'(FlushE), 32'd1);
    advance();

    // Reset in the middle of an op aborts it.
    setIdle();
    MdStartE = 1;
    evalCycle("rmid_T");
    advance();
    rst = 1;
    evalCycle("rmid_T1");
    advance();
    rst = 0; MdStartE = 0;
    evalCycle("rmid_T2");
    chk("rmid_T2.MdBusy_const", 32'(MdBusy), 32'd0);
    chk("rmid_T2.StallF_const", 32'(StallF), 32'd0);
    advance();
    evalCycle("rmid_T3");
    advance();

`ifdef HAZ_PERF_CNT_EN
    // One full op plus one load-use: 4 stall cycles, 4 flush cycles.
    setIdle();
    rst = 1;
    evalCycle("perf_rst");
    advance();
    setIdle();
    MdStartE = 1;
    for (int i = 0; i < MDL; i++) begin
      evalCycle("perf_md");
      advance();
    end
    setIdle();
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    evalCycle("perf_lu");
    advance();
    setIdle();
    evalCycle("perf_end");
    chk("perf.StallCycles_const", StallCycles, 32'd4);
    chk("perf.FlushCount_const", FlushCount, 32'd4);
    advance();
`endif

    // Random traffic with small register indices to provoke matches.
    for (int i = 0; i < 300; i++) begin
      rst        = ($urandom_range(0, 29) == 0);
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      RdM        = AW'($urandom_range(0, 3));
      RdW        = AW'($urandom_range(0, 3));
      Rs1E       = AW'($urandom_range(0, 3));
      Rs2E       = AW'($urandom_range(0, 3));
      RdE        = AW'($urandom_range(0, 3));
      Rs1D       = AW'($urandom_range(0, 3));
      Rs2D       = AW'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 4) == 0);
      MdStartE   = ($urandom_range(0, 3) == 0);
      evalCycle("rand");
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
